// File: rtl/ttl_event_scheduler_if.sv
// Event write channel: a producer offers a timestamped TTL update and the
// scheduler accepts it when ready is high.
interface ttl_event_scheduler_if #(
    parameter int TTL_WIDTH  = 32,
    parameter int TIME_WIDTH = 64
);
    logic                  event_wr_valid;
    logic                  event_wr_ready;
    logic [TIME_WIDTH-1:0] event_wr_time;
    logic [TTL_WIDTH-1:0]  event_wr_value;
    logic [TTL_WIDTH-1:0]  event_wr_mask;

    modport master (
        output event_wr_valid,
        output event_wr_time,
        output event_wr_value,
        output event_wr_mask,
        input  event_wr_ready
    );

    modport slave (
        input  event_wr_valid,
        input  event_wr_time,
        input  event_wr_value,
        input  event_wr_mask,
        output event_wr_ready
    );
endinterface

// File: rtl/ttl_event_scheduler.sv
// Timed TTL event scheduler: queues (time, value, mask) events and applies
// each one to the TTL output register once the running timer reaches it.
module ttl_event_scheduler #(
    parameter int TTL_WIDTH  = 32,
    parameter int TIME_WIDTH = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_areset,
    ttl_event_scheduler_if.slave        ev,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        clear,
    output logic [TTL_WIDTH-1:0]        ttl_value,
    output logic                        ttl_update,
    output logic [TIME_WIDTH-1:0]       timer,
    output logic                        running,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        late_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t state_q, state_d;

    // Event storage; written only, never reset, so it maps onto distributed RAM
    logic [TIME_WIDTH-1:0] mem_time  [FIFO_DEPTH];
    logic [TTL_WIDTH-1:0]  mem_value [FIFO_DEPTH];
    logic [TTL_WIDTH-1:0]  mem_mask  [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [TIME_WIDTH-1:0] timer_q, timer_d;
    logic [TTL_WIDTH-1:0]  ttl_q, ttl_d;
    logic                  upd_q, upd_d;
    logic                  late_q, late_d;

    logic [TIME_WIDTH-1:0] head_time;
    logic [TTL_WIDTH-1:0]  head_value;
    logic [TTL_WIDTH-1:0]  head_mask;
    logic                  wr_ready;
    logic                  push;
    logic                  pop;

    assign head_time  = mem_time[rd_ptr_q];
    assign head_value = mem_value[rd_ptr_q];
    assign head_mask  = mem_mask[rd_ptr_q];

    // Full refuses writes even if a pop happens in the same cycle
    assign wr_ready          = (count_q < DEPTH_C) && !s_axi_areset && !clear;
    assign ev.event_wr_ready = wr_ready;
    assign push              = ev.event_wr_valid && wr_ready;
    assign pop               = (state_q == ST_RUN) && (count_q != '0)
                               && (head_time <= timer_q) && !clear;

    // FSM state register
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clear beats everything, stop beats start
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start && !stop) state_d = ST_RUN;
                ST_RUN:  if (stop)           state_d = ST_IDLE;
                default:                     state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        running = (state_q == ST_RUN);
    end

    // Queue storage write
    always_ff @(posedge s_axi_aclk) begin
        if (push) begin
            mem_time[wr_ptr_q]  <= ev.event_wr_time;
            mem_value[wr_ptr_q] <= ev.event_wr_value;
            mem_mask[wr_ptr_q]  <= ev.event_wr_mask;
        end
    end

    // Datapath next state: queue pointers, timer, TTL merge, late flag
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        timer_d  = (state_q == ST_RUN) ? timer_q + TIME_WIDTH'(1) : timer_q;
        ttl_d    = pop ? ((ttl_q & ~head_mask) | (head_value & head_mask)) : ttl_q;
        upd_d    = pop;
        late_d   = late_q | (pop && (head_time < timer_q));
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            timer_d  = '0;
            late_d   = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            ttl_q    <= '0;
            upd_q    <= 1'b0;
            late_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            ttl_q    <= ttl_d;
            upd_q    <= upd_d;
            late_q   <= late_d;
        end
    end

    assign ttl_value  = ttl_q;
    assign ttl_update = upd_q;
    assign timer      = timer_q;
    assign fifo_count = count_q;
    assign late_error = late_q;
endmodule

// File: tb/tb_ttl_event_scheduler.sv
// Directed bench for ttl_event_scheduler with a scoreboard of expected TTL levels.
module tb_ttl_event_scheduler;
    logic        clk = 1'b0;
    logic        srst;
    logic        start, stop, clear;
    logic [31:0] ttl_value;
    logic        ttl_update;
    logic [63:0] timer;
    logic        running;
    logic [4:0]  fifo_count;
    logic        late_error;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb[$];
    logic [31:0] m_ttl;

    ttl_event_scheduler_if #(.TTL_WIDTH(32), .TIME_WIDTH(64)) bus ();

    ttl_event_scheduler #(
        .TTL_WIDTH(32), .TIME_WIDTH(64), .FIFO_DEPTH(16)
    ) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(srst),
        .ev          (bus),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .ttl_value   (ttl_value),
        .ttl_update  (ttl_update),
        .timer       (timer),
        .running     (running),
        .fifo_count  (fifo_count),
        .late_error  (late_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one event for one cycle; exp_acc says whether the bench expects acceptance
    task automatic push_ev(input logic [63:0] t, input logic [31:0] v,
                           input logic [31:0] m, input logic exp_acc);
        bus.event_wr_valid = 1'b1;
        bus.event_wr_time  = t;
        bus.event_wr_value = v;
        bus.event_wr_mask  = m;
        #1;
        check("wr_ready", bus.event_wr_ready, exp_acc);
        $display("push t=%0d v=%h m=%h expect_accept=%0d", t, v, m, exp_acc);
        if (exp_acc) begin
            m_ttl = (m_ttl & ~m) | (v & m);
            sb.push_back(m_ttl);
        end
        tick();
        bus.event_wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        sb.delete();
        m_ttl = 32'h0;
        tick();
    endtask

    task automatic wait_timer(input logic [63:0] target, input int budget);
        int n = 0;
        while (timer !== target && n < budget) begin tick(); n++; end
        check("timer_reach", timer, target);
    endtask

    task automatic wait_update(input int budget);
        int n = 0;
        while (ttl_update !== 1'b1 && n < budget) begin tick(); n++; end
        check("update_seen", ttl_update, 1'b1);
    endtask

    // Scoreboard: every ttl_update must match the next expected level
    always @(negedge clk) begin
        if (ttl_update === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_update", ttl_update, 1'b0);
            end else begin
                logic [31:0] exp_v;
                exp_v = sb.pop_front();
                $display("update ttl=%h expected=%h timer=%0d", ttl_value, exp_v, timer);
                check("sb_ttl", ttl_value, exp_v);
            end
        end
    end

    initial begin
        srst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        bus.event_wr_valid = 1'b0;
        bus.event_wr_time  = '0;
        bus.event_wr_value = '0;
        bus.event_wr_mask  = '0;
        m_ttl = 32'h0;
        tick(); tick();

        // Reset state
        check("rst_ready", bus.event_wr_ready, 1'b0);
        check("rst_ttl", ttl_value, 32'h0);
        check("rst_timer", timer, 64'h0);
        check("rst_count", fifo_count, 5'd0);
        check("rst_running", running, 1'b0);
        check("rst_update", ttl_update, 1'b0);
        check("rst_late", late_error, 1'b0);
        srst = 1'b0;
        tick();
        check("rel_ready", bus.event_wr_ready, 1'b1);

        // Single event fires the cycle after timer==10
        push_ev(64'd10, 32'h0000_00FF, 32'hFFFF_FFFF, 1'b1);
        check("t1_count", fifo_count, 5'd1);
        pulse_start();
        check("t1_running", running, 1'b1);
        check("t1_timer0", timer, 64'd0);
        wait_timer(64'd10, 40);
        check("t1_noupd_early", ttl_update, 1'b0);
        tick();
        check("t1_ttl", ttl_value, 32'h0000_00FF);
        check("t1_upd", ttl_update, 1'b1);
        check("t1_timer", timer, 64'd11);
        check("t1_late", late_error, 1'b0);
        check("t1_count0", fifo_count, 5'd0);
        tick();
        check("t1_upd_once", ttl_update, 1'b0);

        // Two equal-time events: consecutive pops, second one flagged late
        do_reset();
        push_ev(64'd5, 32'hFFFF_FFFF, 32'h0000_000F, 1'b1);
        push_ev(64'd5, 32'h0000_0000, 32'h0000_0003, 1'b1);
        pulse_start();
        wait_update(40);
        check("t2_first", ttl_value, 32'h0000_000F);
        check("t2_late_first", late_error, 1'b0);
        tick();
        check("t2_upd2", ttl_update, 1'b1);
        check("t2_second", ttl_value, 32'h0000_000C);
        check("t2_late", late_error, 1'b1);

        // Clear from RUN: timer/late/queue cleared, TTL kept
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_timer", timer, 64'h0);
        check("clr_late", late_error, 1'b0);
        check("clr_running", running, 1'b0);
        check("clr_ttl", ttl_value, 32'h0000_000C);
        check("clr_upd", ttl_update, 1'b0);

        // Fill to 16, refuse the 17th, stop in IDLE never pops
        do_reset();
        for (int i = 0; i < 16; i++) push_ev(64'(i), 32'(i), 32'hFFFF_FFFF, 1'b1);
        check("full_count", fifo_count, 5'd16);
        push_ev(64'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
        check("full_count17", fifo_count, 5'd16);
        pulse_stop();
        tick(); tick(); tick();
        check("idle_nopop", fifo_count, 5'd16);
        check("idle_ttl", ttl_value, 32'h0);
        pulse_start();
        // Full with a pop in flight: still refused
        push_ev(64'd200, 32'h0000_0077, 32'hFFFF_FFFF, 1'b0);
        check("pop_refuse_cnt", fifo_count, 5'd15);
        // Simultaneous push and pop keeps the count
        push_ev(64'd200, 32'h0000_0077, 32'hFFFF_FFFF, 1'b1);
        check("pushpop_cnt", fifo_count, 5'd15);
        begin
            int n = 0;
            while (fifo_count !== 5'd0 && n < 400) begin tick(); n++; end
        end
        check("drain_count", fifo_count, 5'd0);
        check("drain_ttl", ttl_value, 32'h0000_0077);
        check("drain_late", late_error, 1'b0);

        // Stop/restart with an event pending
        do_reset();
        push_ev(64'd20, 32'h0000_005A, 32'hFFFF_FFFF, 1'b1);
        pulse_start();
        wait_timer(64'd6, 20);
        pulse_stop();
        check("stop_timer", timer, 64'd7);
        check("stop_running", running, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("stop_hold", timer, 64'd7);
        check("stop_count", fifo_count, 5'd1);
        check("stop_ttl", ttl_value, 32'h0);
        pulse_start();
        wait_timer(64'd20, 40);
        tick();
        check("restart_upd", ttl_update, 1'b1);
        check("restart_ttl", ttl_value, 32'h0000_005A);
        check("restart_timer", timer, 64'd21);

        // Reset mid-run with events queued
        do_reset();
        push_ev(64'd0, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 3; i++) push_ev(64'd1000, 32'h1111_1111, 32'hFFFF_FFFF, 1'b1);
        pulse_start();
        wait_update(10);
        check("pre_rst_ttl", ttl_value, 32'hA5A5_A5A5);
        check("pre_rst_cnt", fifo_count, 5'd3);
        srst = 1'b1;
        tick();
        check("mid_rst_ttl", ttl_value, 32'h0);
        check("mid_rst_timer", timer, 64'h0);
        check("mid_rst_cnt", fifo_count, 5'd0);
        check("mid_rst_run", running, 1'b0);
        check("mid_rst_ready", bus.event_wr_ready, 1'b0);
        srst = 1'b0;
        sb.delete();
        m_ttl = 32'h0;
        tick();

        // Clear with simultaneous start and write
        push_ev(64'd0, 32'h0000_003C, 32'h0000_00FF, 1'b1);
        pulse_start();
        wait_update(10);
        pulse_stop();
        for (int i = 0; i < 4; i++) push_ev(64'd500, 32'h0000_FF00, 32'hFFFF_FFFF, 1'b1);
        check("pre_clr_cnt", fifo_count, 5'd4);
        clear = 1'b1; start = 1'b1;
        bus.event_wr_valid = 1'b1;
        bus.event_wr_time  = 64'd0;
        bus.event_wr_value = 32'hFFFF_FFFF;
        bus.event_wr_mask  = 32'hFFFF_FFFF;
        #1;
        check("clr_ready", bus.event_wr_ready, 1'b0);
        tick();
        clear = 1'b0; start = 1'b0; bus.event_wr_valid = 1'b0;
        sb.delete();
        m_ttl = 32'h0000_003C;
        check("clr2_cnt", fifo_count, 5'd0);
        check("clr2_timer", timer, 64'h0);
        check("clr2_run", running, 1'b0);
        check("clr2_ttl", ttl_value, 32'h0000_003C);
        tick(); tick();
        check("clr2_upd", ttl_update, 1'b0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
